// File: rtl/register_file_scrub.sv
// RV32I integer register file: two combinational read ports, one write port, x0 reads zero.
// After reset the array is scrubbed to zero one register per clock before writes are accepted.
module register_file_scrub #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] register_write_select,
   input  logic [XLEN-1:0]       register_data_write,
   output logic [XLEN-1:0]       register_data_1,
   output logic [XLEN-1:0]       register_data_2,
   output logic                  ready,
   output logic                  write_dropped
);

   typedef enum logic [0:0] {StClear, StReady} state_e;

   localparam logic [ADDR_WIDTH-1:0] LastIndex = ADDR_WIDTH'(REG_COUNT - 1);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clear_index_q;
   logic                  ready_q;
   logic                  write_dropped_q;
   logic [XLEN-1:0]       mem_q [REG_COUNT];
   logic                  write_req;
   logic [XLEN-1:0]       rd1_d;
   logic [XLEN-1:0]       rd2_d;

   assign write_req = write_enable && (register_write_select != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= StClear;
         clear_index_q   <= ADDR_WIDTH'(1);
         ready_q         <= 1'b0;
         write_dropped_q <= 1'b0;
      end else begin
         unique case (state_q)
            StClear: begin
               write_dropped_q <= write_req;
               if (clear_index_q == LastIndex) begin
                  state_q <= StReady;
                  ready_q <= 1'b1;
               end else begin
                  clear_index_q <= clear_index_q + ADDR_WIDTH'(1);
               end
            end
            StReady: begin
               write_dropped_q <= 1'b0;
            end
            default: begin
               state_q         <= StClear;
               clear_index_q   <= ADDR_WIDTH'(1);
               ready_q         <= 1'b0;
               write_dropped_q <= 1'b0;
            end
         endcase
      end
   end

   // The scrub owns the write port while clearing, so a write can never collide with it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state_q == StClear) begin
            mem_q[clear_index_q] <= '0;
         end else if (write_req) begin
            mem_q[register_write_select] <= register_data_write;
         end
      end
   end

   always_comb begin
      rd1_d = '0;
      if (state_q == StReady && rs1 != '0) begin
         if (BYPASS && write_enable && register_write_select == rs1) begin
            rd1_d = register_data_write;
         end else begin
            rd1_d = mem_q[rs1];
         end
      end
   end

   always_comb begin
      rd2_d = '0;
      if (state_q == StReady && rs2 != '0) begin
         if (BYPASS && write_enable && register_write_select == rs2) begin
            rd2_d = register_data_write;
         end else begin
            rd2_d = mem_q[rs2];
         end
      end
   end

   assign register_data_1 = rd1_d;
   assign register_data_2 = rd2_d;
   assign ready           = ready_q;
   assign write_dropped   = write_dropped_q;

endmodule

// File: tb/tb_register_file_scrub.sv
// Drives a bypassing and a non-bypassing register file with the same stimulus and compares
// both against an array-based reference of the scrub / write / read rules.
module tb_register_file_scrub;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        write_enable = 1'b0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [4:0]  register_write_select = '0;
   logic [31:0] register_data_write = '0;

   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        ready_a, ready_b, dropped_a, dropped_b;

   int checks = 0;
   int errors = 0;

   // Reference state: registers, remaining scrub cycles, flags.
   logic [31:0] model_mem [32];
   int          model_left = 0;
   logic        model_ready = 1'b0;
   logic        model_dropped = 1'b0;
   logic        model_valid = 1'b0;

   always #5 clock = ~clock;

   register_file_scrub #(.BYPASS(1'b1)) dut_a (
      .clock                 (clock),
      .reset                 (reset),
      .write_enable          (write_enable),
      .rs1                   (rs1),
      .rs2                   (rs2),
      .register_write_select (register_write_select),
      .register_data_write   (register_data_write),
      .register_data_1       (rd1_a),
      .register_data_2       (rd2_a),
      .ready                 (ready_a),
      .write_dropped         (dropped_a)
   );

   register_file_scrub #(.BYPASS(1'b0)) dut_b (
      .clock                 (clock),
      .reset                 (reset),
      .write_enable          (write_enable),
      .rs1                   (rs1),
      .rs2                   (rs2),
      .register_write_select (register_write_select),
      .register_data_write   (register_data_write),
      .register_data_1       (rd1_b),
      .register_data_2       (rd2_b),
      .ready                 (ready_b),
      .write_dropped         (dropped_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] rs, input bit bypass);
      if (!model_ready || rs == 5'd0) return 32'd0;
      if (bypass && write_enable && register_write_select == rs) return register_data_write;
      return model_mem[rs];
   endfunction

   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
         model_left    = 31;
         model_ready   = 1'b0;
         model_dropped = 1'b0;
         model_valid   = 1'b1;
      end else if (model_left > 0) begin
         model_dropped = write_enable && register_write_select != 5'd0;
         model_left--;
         if (model_left == 0) model_ready = 1'b1;
      end else begin
         model_dropped = 1'b0;
         if (write_enable && register_write_select != 5'd0)
            model_mem[register_write_select] = register_data_write;
      end
   endtask

   // One clock: drive inputs, check combinational reads before the edge, check flags after.
   task automatic cycle(input logic rst, input logic we, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] sel, input logic [31:0] d);
      reset                 = rst;
      write_enable          = we;
      rs1                   = a1;
      rs2                   = a2;
      register_write_select = sel;
      register_data_write   = d;
      #1;
      if (model_valid) begin
         check("rd1_bypass", rd1_a, exp_read(a1, 1'b1));
         check("rd2_bypass", rd2_a, exp_read(a2, 1'b1));
         check("rd1_nobypass", rd1_b, exp_read(a1, 1'b0));
         check("rd2_nobypass", rd2_b, exp_read(a2, 1'b0));
      end
      @(posedge clock);
      model_edge();
      #1;
      check("ready_a", {31'd0, ready_a}, {31'd0, model_ready});
      check("ready_b", {31'd0, ready_b}, {31'd0, model_ready});
      check("dropped_a", {31'd0, dropped_a}, {31'd0, model_dropped});
      check("dropped_b", {31'd0, dropped_b}, {31'd0, model_dropped});
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      cycle(1'b0, 1'b0, a1, a2, 5'd0, 32'd0);
   endtask

   initial begin
      // Reset, then scrub: ready must rise exactly at the 31st edge; a write to x3 mid-scrub
      // is dropped with a one-cycle pulse, a write to x0 mid-scrub is silently ignored.
      cycle(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
      for (int i = 1; i <= 31; i++) begin
         if (i == 10) cycle(1'b0, 1'b1, 5'd5, 5'd3, 5'd3, 32'hA5A5_A5A5);
         else if (i == 12) cycle(1'b0, 1'b1, 5'd5, 5'd3, 5'd0, 32'h1111_2222);
         else idle(5'd5, 5'd3);
         check("ready_at_edge", {31'd0, ready_a}, {31'd0, (i == 31)});
         check("drop_pulse", {31'd0, dropped_a}, {31'd0, (i == 10)});
      end
      idle(5'd3, 5'd3);
      check("x3_after_scrub", rd1_a, 32'd0);

      // Fill x1..x31 with their index and read back crosswise.
      for (int k = 1; k < 32; k++) cycle(1'b0, 1'b1, 5'(k), 5'(31 - k), 5'(k), 32'(k));
      for (int k = 0; k < 32; k++) begin
         idle(5'(k), 5'(31 - k));
         check("cross_rd1", rd1_a, 32'(k));
         check("cross_rd2", rd2_a, 32'(31 - k));
      end

      // Write to x0 is ignored and never flags.
      cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF);
      idle(5'd0, 5'd0);
      check("x0_zero", rd1_a, 32'd0);

      // Same-cycle forwarding on both ports versus stored value.
      reset = 1'b0; write_enable = 1'b1; register_write_select = 5'd7;
      register_data_write = 32'h1234_5678; rs1 = 5'd7; rs2 = 5'd7;
      #1;
      check("bypass_rd1", rd1_a, 32'h1234_5678);
      check("bypass_rd2", rd2_a, 32'h1234_5678);
      check("nobypass_rd1", rd1_b, 32'd7);
      cycle(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h1234_5678);
      idle(5'd7, 5'd7);
      check("x7_stored", rd1_b, 32'h1234_5678);

      // Reset from READY reruns the full scrub.
      cycle(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h55);
      idle(5'd9, 5'd0);
      check("x9_written", rd1_a, 32'h55);
      cycle(1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 32'd0);
      check("ready_drops", {31'd0, ready_a}, 32'd0);
      for (int i = 1; i <= 31; i++) idle(5'd9, 5'd9);
      check("ready_again", {31'd0, ready_a}, 32'd1);
      check("x9_cleared", rd1_a, 32'd0);

      // Randomized traffic with occasional resets, including mid-scrub.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
               5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
